// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus instruction-cache frame and FSM state definitions.
package cpu_types_pkg;

  localparam int unsigned CPU_WORD_W  = 32;
  localparam int unsigned ICACHE_SETS = 16;
  localparam int unsigned IIDX_W      = 4;
  localparam int unsigned ITAG_W      = CPU_WORD_W - 2 - IIDX_W;

  typedef logic [CPU_WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word refill and hit/miss counters.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS   = ICACHE_SETS,
  parameter int unsigned WORD_W = CPU_WORD_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              iflush,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;

  icache_state_t      state;
  logic [SETS-1:0]    valid_q;
  icache_frame_t      frames [SETS];
  icache_frame_t      cur;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   fill_tag;
  logic               lookup_hit;
  logic               hit_c;
  logic               miss_c;
  logic               fill_done;
  logic               unused_low;

  assign unused_low = ^imemaddr[1:0];

  // Lookup against the fetch address; the fill target comes from the latched refill address.
  always_comb begin
    idx        = imemaddr[IDX_W+1:2];
    tag        = imemaddr[WORD_W-1:IDX_W+2];
    fill_idx   = iaddr[IDX_W+1:2];
    fill_tag   = iaddr[WORD_W-1:IDX_W+2];
    cur        = frames[idx];
    lookup_hit = valid_q[idx] & cur.valid & (cur.tag == ITAG_W'(tag));
    hit_c      = (state == IDLE) & imemREN & lookup_hit & ~iflush;
    miss_c     = (state == IDLE) & imemREN & ~lookup_hit & ~iflush;
    fill_done  = (state == FILL) & ~iwait;
    ihit       = hit_c;
    imemload   = hit_c ? WORD_W'(cur.data) : '0;
  end

  // Control FSM, valid vector, refill request and counters.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state    <= IDLE;
      valid_q  <= '0;
      iREN     <= 1'b0;
      iaddr    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_c) hit_cnt <= hit_cnt + 32'd1;
      if (iflush) valid_q <= '0;
      case (state)
        IDLE: begin
          if (miss_c) begin
            state    <= FILL;
            iREN     <= 1'b1;
            iaddr    <= {imemaddr[WORD_W-1:2], 2'b00};
            miss_cnt <= miss_cnt + 32'd1;
          end
        end
        FILL: begin
          if (!iwait) begin
            state <= IDLE;
            iREN  <= 1'b0;
            iaddr <= '0;
            // A flush landing on the completing edge wins over the install.
            if (!iflush) valid_q[fill_idx] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame payload needs no reset; valid_q gates every lookup.
  always_ff @(posedge CLK) begin
    if (fill_done && !iflush) begin
      frames[fill_idx] <= '{valid: 1'b1, tag: ITAG_W'(fill_tag), data: CPU_WORD_W'(iload)};
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboarded random + directed bench for icache against a tag-array reference model.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 CLK = ~CLK;

  icache dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] miss_q[$];
  int          wait_cfg = 0;
  bit          busy = 1'b0;
  int          cnt = 0;
  bit          rv[16];
  logic [25:0] rt[16];
  int          exp_hits = 0;
  int          exp_misses = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h2402_0001;
  endfunction

  function automatic bit predict(input logic [31:0] a);
    return rv[a[5:2]] && (rt[a[5:2]] == a[31:6]);
  endfunction

  task automatic install(input logic [31:0] a);
    rv[a[5:2]] = 1'b1;
    rt[a[5:2]] = a[31:6];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) rv[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ihit must deliver the oldest outstanding expected word.
  always @(negedge CLK) begin
    if (ihit === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_hit: imemload 0x%08h with no fetch outstanding", imemload);
      end else begin
        check("hit_data", imemload, exp_q.pop_front());
      end
    end
  end

  // Memory responder: stalls wait_cfg cycles per refill, checks the refill address.
  always @(negedge CLK) begin
    if (iREN === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = wait_cfg;
        if (miss_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_refill: iaddr 0x%08h with no miss expected", iaddr);
        end else begin
          check("refill_addr", iaddr, miss_q.pop_front());
        end
      end
      if (cnt > 0) begin
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        cnt--;
      end else begin
        iwait = 1'b0;
        iload = mem(iaddr);
      end
    end else begin
      busy  = 1'b0;
      iwait = 1'b1;
      iload = 32'h0;
    end
  end

  task automatic wait_hit(input string name, output int n);
    bit got;
    n   = 0;
    got = (ihit === 1'b1);
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      got = (ihit === 1'b1);
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: no ihit after %0d cycles, got ihit=%b expected 1", name, n, ihit);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
    end
  endtask

  task automatic fetch_w(input logic [31:0] a, input int w);
    bit h;
    int n;
    h = predict(a);
    @(posedge CLK); #1;
    wait_cfg = w;
    imemaddr = a;
    imemREN  = 1'b1;
    exp_q.push_back(mem(a));
    if (!h) miss_q.push_back({a[31:2], 2'b00});
    @(negedge CLK);
    check("hit_predict", 32'(ihit), 32'(h));
    wait_hit("fetch", n);
    if (n < 40) check("latency", 32'(n), h ? 32'd0 : 32'(w + 2));
    install(a);
    exp_hits++;
    if (!h) exp_misses++;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_w(a, int'($urandom_range(0, 3)));
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    imemREN = 1'b0;
    iflush  = 1'b0;
  endtask

  task automatic check_counts();
    @(negedge CLK);
    check("hit_cnt", hit_cnt, 32'(exp_hits));
    check("miss_cnt", miss_cnt, 32'(exp_misses));
  endtask

  initial begin
    int n;
    logic [31:0] a;
    nRST = 1'b1; imemREN = 1'b1; imemaddr = 32'h0; iflush = 1'b0;
    model_clear();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_iren", 32'(iREN), 32'd0);
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b0; imemREN = 1'b0;

    // Cold miss with two wait cycles, then re-fetch hit, then eviction by a same-index tag.
    fetch_w(32'h0000_0000, 2);
    check("first_word", imemload, 32'h2402_0001);
    idle();
    check_counts();
    fetch(32'h0000_0000);
    check("hit_no_iren", 32'(iREN), 32'd0);
    fetch(32'h0000_0040);
    fetch(32'h0000_0000);
    idle();
    check_counts();

    // Redirect during a fill: old refill completes, then the new address misses.
    @(posedge CLK); #1;
    wait_cfg = 2; imemaddr = 32'h4; imemREN = 1'b1;
    miss_q.push_back(32'h4); miss_q.push_back(32'h8); exp_q.push_back(mem(32'h8));
    @(negedge CLK);
    check("redirect_miss", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    imemaddr = 32'h8;
    check("redirect_iren", 32'(iREN), 32'd1);
    check("redirect_iaddr", iaddr, 32'h4);
    @(negedge CLK);
    check("redirect_hold", iaddr, 32'h4);
    wait_hit("redirect", n);
    install(32'h4); install(32'h8);
    exp_misses += 2; exp_hits++;
    fetch(32'h4);
    idle();
    check_counts();

    // Flush in IDLE suppresses a would-be hit and invalidates everything.
    @(posedge CLK); #1;
    imemaddr = 32'h0; imemREN = 1'b1; iflush = 1'b1;
    @(negedge CLK);
    check("flush_forces_miss", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    iflush = 1'b0; imemREN = 1'b0;
    @(negedge CLK);
    check("flush_no_refill", 32'(iREN), 32'd0);
    model_clear();
    fetch(32'h0000_0000);
    idle();

    // Flush coinciding with fill completion: frame is dropped.
    @(posedge CLK); #1;
    wait_cfg = 0; imemaddr = 32'h100; imemREN = 1'b1;
    miss_q.push_back(32'h100);
    @(negedge CLK);
    check("flushfill_miss", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    iflush = 1'b1; imemREN = 1'b0;
    @(negedge CLK);
    check("flushfill_ihit", 32'(ihit), 32'd0);
    check("flushfill_iren", 32'(iREN), 32'd1);
    @(posedge CLK); #1;
    iflush = 1'b0;
    @(negedge CLK);
    check("flushfill_idle", 32'(iREN), 32'd0);
    model_clear();
    exp_misses++;
    fetch(32'h100);
    idle();

    // Flush earlier in a fill: the later install survives.
    @(posedge CLK); #1;
    wait_cfg = 3; imemaddr = 32'h200; imemREN = 1'b1;
    miss_q.push_back(32'h200); exp_q.push_back(mem(32'h200));
    @(negedge CLK);
    check("midflush_miss", 32'(ihit), 32'd0);
    @(posedge CLK); #1;
    iflush = 1'b1;
    @(negedge CLK);
    check("midflush_keeps_fill", 32'(iREN), 32'd1);
    @(posedge CLK); #1;
    iflush = 1'b0;
    wait_hit("midflush", n);
    model_clear(); install(32'h200);
    exp_misses++; exp_hits++;
    fetch(32'h200);
    idle();
    check_counts();

    // Asynchronous reset in the middle of a fill.
    @(posedge CLK); #1;
    wait_cfg = 3; imemaddr = 32'h300; imemREN = 1'b1;
    miss_q.push_back(32'h300);
    @(posedge CLK); #1;
    check("prereset_iren", 32'(iREN), 32'd1);
    @(negedge CLK); #2;
    nRST = 1'b1;
    #1;
    check("async_rst_iren", 32'(iREN), 32'd0);
    check("async_rst_ihit", 32'(ihit), 32'd0);
    check("async_rst_hit_cnt", hit_cnt, 32'h0);
    check("async_rst_miss_cnt", miss_cnt, 32'h0);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b0;
    model_clear();
    exp_hits = 0; exp_misses = 0;

    // Byte offsets within one word share the frame.
    fetch(32'h0000_0007);
    fetch(32'h0000_0004);
    idle();
    check_counts();

    // Randomized fetch stream with occasional flushes.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(posedge CLK); #1;
        imemREN = 1'b0; iflush = 1'b1;
        @(posedge CLK); #1;
        iflush = 1'b0;
        model_clear();
      end else begin
        a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
        fetch(a);
      end
    end
    idle();
    check_counts();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("miss_q_drained", 32'(miss_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
